// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler
//
// Takes signed per-wheel speed commands from the balance/PID logic and
// slew-limits them once per update tick. It converts the limited speeds into
// the sign + 7-bit half-period format used by the dual-channel step-pulse
// motor block. It also owns the motor block's stop control and a command
// watchdog that ramps both wheels to zero when the commander goes silent.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   cmd_valid      a command is present on cmd_speed1/cmd_speed2
//   cmd_ready      block can accept a command (low only around reset)
//   cmd_speed1/2   signed target speeds (two's complement, -128 saturates to -127)
//   motorN_sign    1 = forward (current speed >= 0)
//   motorN_period  127 - |current speed|; 127 is slowest, 0 is fastest
//   drive_reset    stop/hold for the motor block, high while IDLE
//   timeout        high while the watchdog has taken over (TIMEOUT state)
//
// Parameters:
//   UPDATE_DIV     clk cycles per update tick (>= 2)
//   STEP           max change of each wheel speed per tick (1..127)
//   WDOG_TICKS     ticks without an accepted command before timeout (>= 1)

module motor_cmd_scheduler #(
  parameter int UPDATE_DIV = 1000,
  parameter int STEP       = 4,
  parameter int WDOG_TICKS = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_speed1,
  input  logic [7:0] cmd_speed2,
  output logic       motor1_sign,
  output logic [6:0] motor1_period,
  output logic       motor2_sign,
  output logic [6:0] motor2_period,
  output logic       drive_reset,
  output logic       timeout
);

  localparam int PW = $clog2(UPDATE_DIV);
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam int NUM_WHEELS = 2;

  localparam logic signed [8:0] STEP9 = 9'(STEP);
  localparam logic signed [7:0] STEP8 = 8'(STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg;
  logic [WW-1:0]   wdog_reg, wdog_next;
  logic            ready_reg;
  logic            tick;
  logic            accept;
  logic            all_stopped;

  logic signed [7:0] tgt_reg  [NUM_WHEELS];
  logic signed [7:0] tgt_next [NUM_WHEELS];
  logic signed [7:0] cur_reg  [NUM_WHEELS];
  logic signed [7:0] cur_next [NUM_WHEELS];
  logic signed [7:0] cmd_sat  [NUM_WHEELS];
  logic signed [7:0] slew     [NUM_WHEELS];

  logic              sign_reg    [NUM_WHEELS];
  logic              sign_next   [NUM_WHEELS];
  logic [6:0]        period_reg  [NUM_WHEELS];
  logic [6:0]        period_next [NUM_WHEELS];
  logic              drive_reset_reg, timeout_reg;

  assign tick        = (presc_reg == PW'(UPDATE_DIV - 1));
  assign accept      = cmd_valid && ready_reg;
  assign all_stopped = (cur_reg[0] == 8'sd0) && (cur_reg[1] == 8'sd0);

  // ---------------------------------------------------------------------------
  // Per-wheel datapath: command saturation, one slew step, output formatting.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_WHEELS; gi++) begin : g_wheel
      logic signed [7:0] raw_w;
      logic signed [8:0] diff_w;
      logic signed [7:0] slew_w;
      logic [6:0]        mag_w;

      assign raw_w = (gi == 0) ? cmd_speed1 : cmd_speed2;

      // -128 has no positive mirror in the period format, so clamp it.
      assign cmd_sat[gi] = (raw_w == 8'sh80) ? 8'sh81 : raw_w;

      // 9-bit difference so +127 - (-127) cannot wrap.
      assign diff_w = {tgt_reg[gi][7], tgt_reg[gi]} - {cur_reg[gi][7], cur_reg[gi]};

      // Stepping by STEP only when |d| > STEP keeps cur between its old value
      // and tgt, so cur never leaves -127..127.
      always_comb begin
        slew_w = tgt_reg[gi];
        if (diff_w > STEP9) begin
          slew_w = cur_reg[gi] + STEP8;
        end else if (diff_w < -STEP9) begin
          slew_w = cur_reg[gi] - STEP8;
        end
      end

      assign slew[gi] = slew_w;

      // |cur| fits in 7 bits because -128 can never be reached.
      assign mag_w = cur_next[gi][7] ? 7'(-cur_next[gi]) : cur_next[gi][6:0];

      // Outputs are computed from the next value so they move on the same
      // edge as cur itself.
      assign sign_next[gi]   = ~cur_next[gi][7];
      assign period_next[gi] = 7'd127 - mag_w;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, watchdog, targets, slew.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    wdog_next  = wdog_reg;
    for (int i = 0; i < NUM_WHEELS; i++) begin
      tgt_next[i] = tgt_reg[i];
      cur_next[i] = cur_reg[i];
    end

    // Slew always works from the pre-edge target. A command accepted on a
    // tick edge therefore takes effect on the following tick.
    if (tick && (state_reg != IDLE)) begin
      for (int i = 0; i < NUM_WHEELS; i++) begin
        cur_next[i] = slew[i];
      end
    end

    case (state_reg)
      RUN: begin
        if (tick) begin
          if (int'(wdog_reg) + 1 >= WDOG_TICKS) begin
            state_next = TIMEOUT;
            wdog_next  = '0;
            for (int i = 0; i < NUM_WHEELS; i++) begin
              tgt_next[i] = 8'sd0;
            end
          end else begin
            wdog_next = wdog_reg + WW'(1);
          end
        end
      end
      TIMEOUT: begin
        // Judge "stopped" on cur before this tick's slew, so the wheels are
        // seen at zero for a full tick before the motor block is released.
        if (tick && all_stopped) begin
          state_next = IDLE;
        end
      end
      default: begin
        // IDLE: cur and tgt are already zero and stay there.
      end
    endcase

    // An accepted command overrides any watchdog action on the same edge.
    if (accept) begin
      state_next = RUN;
      wdog_next  = '0;
      for (int i = 0; i < NUM_WHEELS; i++) begin
        tgt_next[i] = cmd_sat[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      presc_reg       <= '0;
      wdog_reg        <= '0;
      ready_reg       <= 1'b0;
      drive_reset_reg <= 1'b1;
      timeout_reg     <= 1'b0;
      for (int i = 0; i < NUM_WHEELS; i++) begin
        tgt_reg[i]    <= 8'sd0;
        cur_reg[i]    <= 8'sd0;
        sign_reg[i]   <= 1'b1;
        period_reg[i] <= 7'd127;
      end
    end else begin
      state_reg       <= state_next;
      presc_reg       <= tick ? '0 : presc_reg + PW'(1);
      wdog_reg        <= wdog_next;
      ready_reg       <= 1'b1;
      drive_reset_reg <= (state_next == IDLE);
      timeout_reg     <= (state_next == TIMEOUT);
      for (int i = 0; i < NUM_WHEELS; i++) begin
        tgt_reg[i]    <= tgt_next[i];
        cur_reg[i]    <= cur_next[i];
        sign_reg[i]   <= sign_next[i];
        period_reg[i] <= period_next[i];
      end
    end
  end

  assign cmd_ready     = ready_reg;
  assign motor1_sign   = sign_reg[0];
  assign motor1_period = period_reg[0];
  assign motor2_sign   = sign_reg[1];
  assign motor2_period = period_reg[1];
  assign drive_reset   = drive_reset_reg;
  assign timeout       = timeout_reg;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Testbench for motor_cmd_scheduler: directed scenarios followed by random
// commands and resets. Every cycle, all outputs are compared against a
// behavioural model that applies the block's rules with integer arithmetic.
module tb_motor_cmd_scheduler;

  localparam int UDIV = 4;
  localparam int STP  = 4;
  localparam int WDT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_speed1 = 8'd0;
  logic [7:0] cmd_speed2 = 8'd0;
  logic       motor1_sign, motor2_sign;
  logic [6:0] motor1_period, motor2_period;
  logic       drive_reset, timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: 0 = idle, 1 = run, 2 = timeout.
  int m_state, m_presc, m_wdog, m_ready, m_ticks;
  int m_tgt[2];
  int m_cur[2];

  motor_cmd_scheduler #(
    .UPDATE_DIV (UDIV),
    .STEP       (STP),
    .WDOG_TICKS (WDT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_speed1    (cmd_speed1),
    .cmd_speed2    (cmd_speed2),
    .motor1_sign   (motor1_sign),
    .motor1_period (motor1_period),
    .motor2_sign   (motor2_sign),
    .motor2_period (motor2_period),
    .drive_reset   (drive_reset),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int move_toward(input int cur, input int tgt);
    if (iabs(tgt - cur) <= STP) return tgt;
    return (tgt > cur) ? cur + STP : cur - STP;
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_wdog = 0; m_ready = 0;
    m_tgt[0] = 0; m_tgt[1] = 0; m_cur[0] = 0; m_cur[1] = 0;
  endtask

  // One clock edge of the reference model, from the inputs seen at that edge.
  task automatic model_step(input logic r, input logic v, input int s1, input int s2);
    bit tk, acc, was_stopped;
    if (r) begin
      model_reset();
      return;
    end
    tk          = (m_presc == UDIV - 1);
    acc         = v && (m_ready != 0);
    was_stopped = (m_cur[0] == 0) && (m_cur[1] == 0);
    m_presc     = tk ? 0 : m_presc + 1;
    if (tk) m_ticks++;
    if (tk && m_state != 0) begin
      m_cur[0] = move_toward(m_cur[0], m_tgt[0]);
      m_cur[1] = move_toward(m_cur[1], m_tgt[1]);
    end
    if (acc) begin
      m_tgt[0] = (s1 < -127) ? -127 : s1;
      m_tgt[1] = (s2 < -127) ? -127 : s2;
      m_wdog   = 0;
      m_state  = 1;
    end else if (tk && m_state == 1) begin
      m_wdog++;
      if (m_wdog >= WDT) begin
        m_state  = 2;
        m_tgt[0] = 0;
        m_tgt[1] = 0;
      end
    end else if (tk && m_state == 2 && was_stopped) begin
      m_state = 0;
    end
    m_ready = 1;
  endtask

  task automatic check_outputs();
    check("cmd_ready",     int'(cmd_ready),     m_ready);
    check("motor1_sign",   int'(motor1_sign),   (m_cur[0] >= 0) ? 1 : 0);
    check("motor1_period", int'(motor1_period), 127 - iabs(m_cur[0]));
    check("motor2_sign",   int'(motor2_sign),   (m_cur[1] >= 0) ? 1 : 0);
    check("motor2_period", int'(motor2_period), 127 - iabs(m_cur[1]));
    check("drive_reset",   int'(drive_reset),   (m_state == 0) ? 1 : 0);
    check("timeout",       int'(timeout),       (m_state == 2) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, step the model on the edge, compare at negedge.
  task automatic cycle(input logic r, input logic v, input int s1, input int s2);
    reset      = r;
    cmd_valid  = v;
    cmd_speed1 = s1[7:0];
    cmd_speed2 = s2[7:0];
    if (!r && v && m_ready != 0)
      $display("txn accept speed1=%0d speed2=%0d t=%0t", s1, s2, $time);
    @(posedge clk);
    model_step(r, v, s1, s2);
    @(negedge clk);
    check_outputs();
  endtask

  // Run cycles with fixed inputs until n more ticks have been applied.
  task automatic run_ticks(input int n, input logic v, input int s1, input int s2);
    int start, guard;
    start = m_ticks;
    guard = 0;
    while ((m_ticks - start) < n && guard < n * UDIV + 8) begin
      cycle(1'b0, v, s1, s2);
      guard++;
    end
    check("tick_budget", m_ticks - start, n);
  endtask

  initial begin
    int r_s1, r_s2;
    logic r_r, r_v;
    model_reset();
    m_ticks = 0;

    // 1. Reset, including a command offered during reset.
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 50, 50);
    cycle(1'b1, 1'b0, 0, 0);
    check("d1_ready_in_reset", int'(cmd_ready), 0);
    check("d1_drive_in_reset", int'(drive_reset), 1);
    cycle(1'b0, 1'b0, 0, 0);
    check("d1_ready_after", int'(cmd_ready), 1);
    run_ticks(1, 1'b0, 0, 0);
    check("d1_tick_period1", int'(motor1_period), 127);
    check("d1_tick_drive", int'(drive_reset), 1);

    // 2. Basic slew: +10 / -6.
    run_ticks(1, 1'b1, 10, -6);
    check("d2_drive", int'(drive_reset), 0);
    check("d2_p1_t1", int'(motor1_period), 123);
    check("d2_p2_t1", int'(motor2_period), 123);
    check("d2_s2_t1", int'(motor2_sign), 0);
    run_ticks(2, 1'b1, 10, -6);
    check("d2_p1_t3", int'(motor1_period), 117);
    check("d2_p2_t3", int'(motor2_period), 121);

    // 3. -128 saturates to -127 (full speed reverse).
    run_ticks(40, 1'b1, -128, 0);
    check("d3_p1", int'(motor1_period), 0);
    check("d3_s1", int'(motor1_sign), 0);
    check("d3_p2", int'(motor2_period), 127);

    // 4. Accept coincident with a tick uses the old target on that tick.
    run_ticks(35, 1'b1, 0, 0);
    for (int k = 0; k < 8 && m_presc != UDIV - 1; k++) cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 20, 0);
    check("d4_coincident", int'(motor1_period), 127);
    run_ticks(1, 1'b0, 0, 0);
    check("d4_next_tick", int'(motor1_period), 123);

    // 5. Watchdog timeout and ramp-down to IDLE.
    run_ticks(3, 1'b1, 10, 0);
    check("d5_start", int'(motor1_period), 117);
    run_ticks(2, 1'b0, 0, 0);
    check("d5_no_timeout", int'(timeout), 0);
    run_ticks(1, 1'b0, 0, 0);
    check("d5_timeout", int'(timeout), 1);
    check("d5_hold", int'(motor1_period), 117);
    run_ticks(3, 1'b0, 0, 0);
    check("d5_ramped", int'(motor1_period), 127);
    check("d5_still_to", int'(timeout), 1);
    check("d5_drive_low", int'(drive_reset), 0);
    run_ticks(1, 1'b0, 0, 0);
    check("d5_idle_drive", int'(drive_reset), 1);
    check("d5_idle_to", int'(timeout), 0);

    // 6. Reset mid-slew drops the concurrent command.
    run_ticks(2, 1'b1, 30, 0);
    check("d6_mid", int'(motor1_period), 119);
    cycle(1'b1, 1'b1, 50, 50);
    check("d6_period", int'(motor1_period), 127);
    check("d6_drive", int'(drive_reset), 1);
    check("d6_ready", int'(cmd_ready), 0);
    cycle(1'b0, 1'b1, 50, 50);
    check("d6_not_accepted", int'(drive_reset), 1);

    // Random phase: sparse commands so the watchdog fires, rare resets.
    for (int i = 0; i < 3000; i++) begin
      r_r  = ($urandom_range(0, 599) == 0);
      r_v  = ($urandom_range(0, 7) == 0);
      r_s1 = int'($urandom_range(0, 255)) - 128;
      r_s2 = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 9) == 0) r_s1 = -128;
      if ($urandom_range(0, 9) == 0) r_s2 = 0;
      cycle(r_r, r_v, r_s1, r_s2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_scheduler.md
Name: motor_cmd_scheduler

Overview:
Sits between the balance/PID logic and the dual-channel motor_controller step-pulse block. It accepts signed per-wheel speed commands over a valid/ready handshake and slew-limits them once per update tick. It converts the limited speeds to the sign + 7-bit period format the motor block consumes. It also owns the motor block's stop control (drive_reset) and a command watchdog that ramps both wheels to zero if the commander goes silent.

Parameters:
UPDATE_DIV, 1000, clk cycles per update tick (>=2)
STEP, 4, max change of each wheel speed per tick (1..127)
WDOG_TICKS, 50, ticks without an accepted command before timeout (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_speed1  in  8  signed target speed, wheel 1 (two's complement)
cmd_speed2  in  8  signed target speed, wheel 2
motor1_sign  out  1  1 = forward (speed >= 0)
motor1_period  out  7  step half-period for wheel 1
motor2_sign  out  1  as motor1_sign for wheel 2
motor2_period  out  7  as motor1_period for wheel 2
drive_reset  out  1  stop/hold for motor block, active-high
timeout  out  1  high while in TIMEOUT state

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE; tgt1, tgt2, cur1, cur2 = 0; prescaler = 0; wdog = 0.
  - cmd_ready=0 during reset cycles, 1 from first cycle after reset deasserts.
  - motorN_sign=1, motorN_period=127, drive_reset=1, timeout=0.
- Prescaler: counts 0..UPDATE_DIV-1 and wraps. tick is a 1-cycle internal pulse when count==UPDATE_DIV-1. The first tick after reset occurs on cycle UPDATE_DIV.
- Accept: happens when cmd_valid && cmd_ready.
  - tgtN <= cmd_speedN, with -128 saturated to -127.
  - wdog <= 0; state IDLE/TIMEOUT/RUN -> RUN.
  - cmd_ready stays 1 (one command per cycle max). The last accepted command before a tick wins.
- On tick, per wheel, using 9-bit signed arithmetic (no wrap):
  - d = tgtN - curN.
  - If |d| <= STEP, curN <= tgtN; else curN <= curN ± STEP toward tgtN.
  - cur never leaves -127..127.
- Simultaneous accept and tick: the slew uses tgt as it was before that edge; the new target applies from the next tick. Accept's wdog clear wins over the tick increment.
- Watchdog (RUN only):
  - On a tick with no accept, wdog increments (saturating).
  - When the incremented value reaches WDOG_TICKS: state -> TIMEOUT, tgt1 = tgt2 = 0 on the same edge.
- TIMEOUT:
  - Wheels keep slewing to 0 at STEP per tick.
  - On a tick where both cur are already 0: state -> IDLE.
  - An accept exits to RUN immediately with the new targets.
- IDLE: cur held at 0, no slew needed. drive_reset=1.
- Outputs (direct from registers; they change on the tick edge, 0 cycles after cur):
  - motorN_sign = (curN >= 0).
  - motorN_period = 127 - |curN|, so 0 maps to 127 (slowest) and ±127 maps to 0 (fastest).
  - drive_reset = (state==IDLE).
  - timeout = (state==TIMEOUT).
- Reset mid-operation: all registers return to reset values on that edge. A pending command in the same cycle is dropped. Slewing does not continue.
- A zero command in RUN keeps RUN with period 127 and drive_reset=0. Only the watchdog path returns to IDLE.

Test Plan:
(All with UPDATE_DIV=4, STEP=4, WDOG_TICKS=3.)
1. Reset 3 cycles, release -> cmd_ready=1 from next cycle; drive_reset=1, periods 127, signs 1; first tick at cycle 4 changes nothing.
2. Accept (speed1=+10, speed2=-6) -> state RUN, drive_reset=0 next cycle. cur1 over ticks 4, 8, 10 (periods 123, 119, 117). cur2 over ticks -4, -6 (sign2=0, periods 123, 121).
3. Accept speed1=-128 -> saturates to -127. From cur1=0, 32 ticks to reach -127, then period1=0, sign1=0.
4. Accept coincident with tick while cur1=0, old tgt1=0, new speed1=20 -> cur1 stays 0 that tick, becomes 4 next tick; wdog reads 0.
5. From cur1=10, no commands for 3 ticks -> timeout=1 on 3rd tick. cur1 goes 6, 2, 0 on following ticks. One tick later: IDLE, drive_reset=1, timeout=0.
6. Assert reset mid-slew (cur1=8) -> next edge cur1=0, period 127, drive_reset=1. A cmd_valid in the reset cycle is not accepted.
